// File: rtl/approx_adder_arbiter.sv
// -----------------------------------------------------------------------------
// approx_adder_arbiter
//
// Purpose
//   Shares one 16-bit Brent-Kung approximate adder among N_REQ requesters.
//   A round-robin arbiter picks one requester per cycle. Its operands are
//   registered in stage S1. The adder is purely combinational on S1, and its
//   result is registered in stage S2, which drives the response port. The
//   pipeline sustains one operation per cycle. Each response carries the id of
//   the requester that issued it.
//
//   Approximation: in the low byte, the carry into bit i is just the generate
//   of bit i-1. There is no carry propagation. The carry into bit 8 is g[7].
//   The high byte is an exact 8-bit Brent-Kung prefix adder that takes that
//   carry as its carry-in. The adder carry-in is tied to 0.
//
// Optional feature (compile-time macro APPROX_ERR_MON_EN)
//   When defined, an exact 17-bit sum is computed from S1 in parallel with the
//   approximate adder and registered into S2. In that build:
//     rsp_exact is 1 when the approximate result equals the exact one.
//     err_cnt is a saturating count of response handshakes with rsp_exact=0.
//   When undefined, neither port exists and none of this logic is built.
//
// Ports
//   clk        in   1          clock, all state on rising edge
//   rst        in   1          synchronous reset, active-high
//   req_valid  in   N_REQ      per-requester operand valid
//   req_ready  out  N_REQ      per-requester accept, one-hot or zero
//   req_a      in   16*N_REQ   operand A, requester i at [16*i+15:16*i]
//   req_b      in   16*N_REQ   operand B, same packing
//   rsp_valid  out  1          result valid
//   rsp_ready  in   1          consumer accepts result
//   rsp_sum    out  16         approximate sum
//   rsp_cout   out  1          approximate carry-out (bit 16)
//   rsp_id     out  ID_W       index of the requester that issued the op
//   err_cnt    out  CNT_W      saturating mismatch count (APPROX_ERR_MON_EN only)
//   rsp_exact  out  1          approx result equals exact (APPROX_ERR_MON_EN only)
// -----------------------------------------------------------------------------
module approx_adder_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [16*N_REQ-1:0]   req_a,
   input  logic [16*N_REQ-1:0]   req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [15:0]           rsp_sum,
   output logic                  rsp_cout,
   output logic [ID_W-1:0]       rsp_id
`ifdef APPROX_ERR_MON_EN
   ,
   output logic [CNT_W-1:0]      err_cnt,
   output logic                  rsp_exact
`endif
);

   localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   // ---------------------------------------------------------------- state
   logic               s1_valid_q, s1_valid_d;
   logic [15:0]        s1_a_q,     s1_a_d;
   logic [15:0]        s1_b_q,     s1_b_d;
   logic [ID_W-1:0]    s1_id_q,    s1_id_d;
   logic               s2_valid_q, s2_valid_d;
   logic [15:0]        s2_sum_q,   s2_sum_d;
   logic               s2_cout_q,  s2_cout_d;
   logic [ID_W-1:0]    s2_id_q,    s2_id_d;
   logic [SEL_W-1:0]   rr_ptr_q,   rr_ptr_d;

`ifdef APPROX_ERR_MON_EN
   logic [16:0]        s2_exact_q, s2_exact_d;
   logic [CNT_W-1:0]   err_cnt_q,  err_cnt_d;
   logic               exact_match;
`else
   // Keeps CNT_W referenced in the build without the error monitor.
   logic [CNT_W-1:0]   unused_cnt_w;
   assign unused_cnt_w = '0;
`endif

   // ---------------------------------------------------------------- control
   logic               s2_adv;
   logic               s1_free;
   logic               grant_found;
   logic [SEL_W-1:0]   grant_sel;
   logic [N_REQ-1:0]   grant_oh;
   logic               xfer;
   logic [15:0]        sel_a;
   logic [15:0]        sel_b;

   // ---------------------------------------------------------------- adder
   logic [15:0]        add_g;
   logic [15:0]        add_p;
   logic               carry_8;
   logic [7:0]         bk_g;
   logic [7:0]         bk_p;
   logic [15:0]        add_sum;
   logic               add_cout;

   // S2 drains or is empty -> S1 may move forward. S1 can accept new operands
   // when it is empty or is moving into S2 on this same edge.
   assign s2_adv  = s1_valid_q & (~s2_valid_q | rsp_ready);
   assign s1_free = ~s1_valid_q | s2_adv;

   // Round-robin search starting at rr_ptr, wrapping from N_REQ-1 back to 0.
   // NOTE: every variable written in a combinational block gets a default at
   // the top, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      grant_found = 1'b0;
      grant_sel   = '0;
      grant_oh    = '0;
      for (int off = 0; off < N_REQ; off++) begin
         logic [SEL_W-1:0] idx;
         idx = SEL_W'((int'(rr_ptr_q) + off) % N_REQ);
         if (!grant_found && req_valid[idx]) begin
            grant_found   = 1'b1;
            grant_sel     = idx;
            grant_oh[idx] = 1'b1;
         end
      end
   end

   // Only the winner sees ready, and only when S1 can take it. Ready is also
   // held low while reset is asserted.
   assign req_ready = grant_oh & {N_REQ{s1_free & ~rst}};
   assign xfer      = |(req_valid & req_ready);

   // Operand mux driven by the one-hot grant.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_oh[i]) begin
            sel_a = req_a[16*i +: 16];
            sel_b = req_b[16*i +: 16];
         end
      end
   end

   // Approximate Brent-Kung adder on the S1 operands, carry-in = 0.
   assign add_g   = s1_a_q & s1_b_q;
   assign add_p   = s1_a_q ^ s1_b_q;
   assign carry_8 = add_g[7];

   // The high-byte prefix tree is evaluated in place. Each step overwrites a
   // node with the (G,P) span ending at that bit, so statement order is the
   // tree order.
   // NOTE: blocking assignments here are intentional. Each stage reads the
   // value produced by the previous line in the same evaluation.
   always_comb begin
      bk_g    = add_g[15:8];
      bk_p    = add_p[15:8];
      bk_g[0] = add_g[8] | (add_p[8] & carry_8);
      // up-sweep, span 2
      bk_g[1] = bk_g[1] | (bk_p[1] & bk_g[0]);  bk_p[1] = bk_p[1] & bk_p[0];
      bk_g[3] = bk_g[3] | (bk_p[3] & bk_g[2]);  bk_p[3] = bk_p[3] & bk_p[2];
      bk_g[5] = bk_g[5] | (bk_p[5] & bk_g[4]);  bk_p[5] = bk_p[5] & bk_p[4];
      bk_g[7] = bk_g[7] | (bk_p[7] & bk_g[6]);  bk_p[7] = bk_p[7] & bk_p[6];
      // up-sweep, span 4
      bk_g[3] = bk_g[3] | (bk_p[3] & bk_g[1]);  bk_p[3] = bk_p[3] & bk_p[1];
      bk_g[7] = bk_g[7] | (bk_p[7] & bk_g[5]);  bk_p[7] = bk_p[7] & bk_p[5];
      // up-sweep, span 8
      bk_g[7] = bk_g[7] | (bk_p[7] & bk_g[3]);  bk_p[7] = bk_p[7] & bk_p[3];
      // down-sweep
      bk_g[5] = bk_g[5] | (bk_p[5] & bk_g[3]);  bk_p[5] = bk_p[5] & bk_p[3];
      bk_g[2] = bk_g[2] | (bk_p[2] & bk_g[1]);  bk_p[2] = bk_p[2] & bk_p[1];
      bk_g[4] = bk_g[4] | (bk_p[4] & bk_g[3]);  bk_p[4] = bk_p[4] & bk_p[3];
      bk_g[6] = bk_g[6] | (bk_p[6] & bk_g[5]);  bk_p[6] = bk_p[6] & bk_p[5];
   end

   // Low byte: single-level carry (generate of the bit below only).
   assign add_sum[7:0]  = add_p[7:0]  ^ {add_g[6:0], 1'b0};
   assign add_sum[15:8] = add_p[15:8] ^ {bk_g[6:0], carry_8};
   assign add_cout      = bk_g[7];

`ifdef APPROX_ERR_MON_EN
   assign exact_match = ({s2_cout_q, s2_sum_q} == s2_exact_q);
`endif

   // ---------------------------------------------------------------- next state
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_id_d    = s1_id_q;
      s2_valid_d = s2_valid_q;
      s2_sum_d   = s2_sum_q;
      s2_cout_d  = s2_cout_q;
      s2_id_d    = s2_id_q;
      rr_ptr_d   = rr_ptr_q;
`ifdef APPROX_ERR_MON_EN
      s2_exact_d = s2_exact_q;
      err_cnt_d  = err_cnt_q;
`endif

      // S1: a new transfer wins. Otherwise S1 empties when it moves to S2.
      if (xfer) begin
         s1_valid_d = 1'b1;
         s1_a_d     = sel_a;
         s1_b_d     = sel_b;
         s1_id_d    = ID_W'(grant_sel);
         rr_ptr_d   = (grant_sel == SEL_W'(N_REQ - 1)) ? '0 : grant_sel + 1'b1;
      end else if (s2_adv) begin
         s1_valid_d = 1'b0;
      end

      // S2: load from the adder, or empty once the consumer takes the result.
      if (s2_adv) begin
         s2_valid_d = 1'b1;
         s2_sum_d   = add_sum;
         s2_cout_d  = add_cout;
         s2_id_d    = s1_id_q;
`ifdef APPROX_ERR_MON_EN
         s2_exact_d = {1'b0, s1_a_q} + {1'b0, s1_b_q};
`endif
      end else if (rsp_ready) begin
         s2_valid_d = 1'b0;
      end

`ifdef APPROX_ERR_MON_EN
      if (s2_valid_q && rsp_ready && !exact_match && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
`endif
   end

   // ---------------------------------------------------------------- registers
   // NOTE: the datapath registers are reset along with the valids so that the
   // response fields read 0 after reset. The valids alone would be enough to
   // discard in-flight work.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_id_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_sum_q   <= '0;
         s2_cout_q  <= 1'b0;
         s2_id_q    <= '0;
         rr_ptr_q   <= '0;
`ifdef APPROX_ERR_MON_EN
         s2_exact_q <= '0;
         err_cnt_q  <= '0;
`endif
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_id_q    <= s1_id_d;
         s2_valid_q <= s2_valid_d;
         s2_sum_q   <= s2_sum_d;
         s2_cout_q  <= s2_cout_d;
         s2_id_q    <= s2_id_d;
         rr_ptr_q   <= rr_ptr_d;
`ifdef APPROX_ERR_MON_EN
         s2_exact_q <= s2_exact_d;
         err_cnt_q  <= err_cnt_d;
`endif
      end
   end

   // ---------------------------------------------------------------- outputs
   assign rsp_valid = s2_valid_q;
   assign rsp_sum   = s2_sum_q;
   assign rsp_cout  = s2_cout_q;
   assign rsp_id    = s2_id_q;
`ifdef APPROX_ERR_MON_EN
   assign rsp_exact = exact_match;
   assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_approx_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_approx_adder_arbiter
//
// Directed bench for approx_adder_arbiter. It checks:
//   - reset state and single-op latency
//   - strict round-robin rotation
//   - backpressure hold and in-order release
//   - approximate low-byte carry behaviour
//   - reset while the pipeline is full
//   - saturating error counter (APPROX_ERR_MON_EN builds, CNT_W=2)
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_approx_adder_arbiter;

   localparam int N_REQ = 4;
   localparam int ID_W  = 2;
   localparam int CNT_W = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N_REQ-1:0]     req_valid;
   logic [N_REQ-1:0]     req_ready;
   logic [16*N_REQ-1:0]  req_a;
   logic [16*N_REQ-1:0]  req_b;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [15:0]          rsp_sum;
   logic                 rsp_cout;
   logic [ID_W-1:0]      rsp_id;
`ifdef APPROX_ERR_MON_EN
   logic [CNT_W-1:0]     err_cnt;
   logic                 rsp_exact;
`endif

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   approx_adder_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .rsp_id    (rsp_id)
`ifdef APPROX_ERR_MON_EN
      ,
      .err_cnt   (err_cnt),
      .rsp_exact (rsp_exact)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then sample/drive 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
      req_a[16*i +: 16] = a;
      req_b[16*i +: 16] = b;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      tick();
      rst       = 1'b0;
   endtask

   // One isolated op from requester id with rsp_ready=1. exp_cnt is the error
   // count expected after the response handshake.
   task automatic single_op(input string tag, input int id,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] exp_sum, input logic exp_cout,
                            input logic exp_exact, input logic [CNT_W-1:0] exp_cnt);
      set_op(id, a, b);
      req_valid     = '0;
      req_valid[id] = 1'b1;
      #1;
      check({tag, ".ready"}, req_ready, 32'(1) << id);
      tick();
      req_valid = '0;
      tick();
      check({tag, ".valid"}, rsp_valid, 1);
      check({tag, ".sum"},   rsp_sum,   exp_sum);
      check({tag, ".cout"},  rsp_cout,  exp_cout);
      check({tag, ".id"},    rsp_id,    id);
`ifdef APPROX_ERR_MON_EN
      check({tag, ".exact"}, rsp_exact, exp_exact);
`endif
      tick();
      check({tag, ".drained"}, rsp_valid, 0);
`ifdef APPROX_ERR_MON_EN
      check({tag, ".err_cnt"}, err_cnt, exp_cnt);
`else
      if (exp_exact === 1'bx || exp_cnt === 'x) $display("unexpected X argument");
`endif
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;

      // ---- reset state
      tick();
      tick();
      check("rst.rsp_valid", rsp_valid, 0);
      check("rst.rsp_sum",   rsp_sum,   0);
      check("rst.rsp_cout",  rsp_cout,  0);
      check("rst.rsp_id",    rsp_id,    0);
      check("rst.req_ready", req_ready, 0);
`ifdef APPROX_ERR_MON_EN
      check("rst.err_cnt",   err_cnt,   0);
`endif

      // ---- 1: single op, two-edge latency
      rst = 1'b0;
      set_op(0, 16'h1234, 16'h0101);
      req_valid = 4'b0001;
      #1;
      check("t1.ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      check("t1.lat1", rsp_valid, 0);
      tick();
      check("t1.valid", rsp_valid, 1);
      check("t1.sum",   rsp_sum,   16'h1335);
      check("t1.cout",  rsp_cout,  0);
      check("t1.id",    rsp_id,    0);
      tick();
      check("t1.drain", rsp_valid, 0);

      // ---- 2: all valid -> rotation 0,1,2,3,0,1
      do_reset();
      for (int i = 0; i < N_REQ; i++) set_op(i, 16'(i), 16'h0A00);
      req_valid = 4'b1111;
      #1;
      check("t2.ready0", req_ready, 4'b0001);
      tick();
      for (int k = 0; k < 6; k++) begin
         tick();
         check($sformatf("t2.valid%0d", k), rsp_valid, 1);
         check($sformatf("t2.id%0d", k),    rsp_id,    k % 4);
         check($sformatf("t2.sum%0d", k),   rsp_sum,   16'h0A00 + 16'(k % 4));
      end
      req_valid = '0;
      tick();
      tick();
      tick();

      // ---- 3: backpressure
      do_reset();
      rsp_ready = 1'b0;
      set_op(1, 16'h1000, 16'h0001);
      set_op(2, 16'h2000, 16'h0002);
      set_op(3, 16'h3000, 16'h0003);
      req_valid = 4'b0110;
      #1;
      check("t3.ready_r1", req_ready, 4'b0010);
      tick();
      req_valid = 4'b0100;
      #1;
      check("t3.ready_r2", req_ready, 4'b0100);
      tick();
      req_valid = 4'b1000;
      #1;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("t3.hold_valid%0d", k), rsp_valid, 1);
         check($sformatf("t3.hold_id%0d", k),    rsp_id,    1);
         check($sformatf("t3.hold_sum%0d", k),   rsp_sum,   16'h1001);
         check($sformatf("t3.hold_ready%0d", k), req_ready, 0);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      check("t3.rel_ready", req_ready, 4'b1000);
      check("t3.rel_id1",   rsp_id,    1);
      tick();
      req_valid = '0;
      check("t3.valid2", rsp_valid, 1);
      check("t3.id2",    rsp_id,    2);
      check("t3.sum2",   rsp_sum,   16'h2002);
      tick();
      check("t3.valid3", rsp_valid, 1);
      check("t3.id3",    rsp_id,    3);
      check("t3.sum3",   rsp_sum,   16'h3003);
      tick();
      check("t3.empty",  rsp_valid, 0);

      // ---- 4: approximate arithmetic
      do_reset();
      single_op("t4.ff_01",   3, 16'h00FF, 16'h0001, 16'h00FC, 1'b0, 1'b0, 2'd1);
      single_op("t4.1234",    0, 16'h1234, 16'h0101, 16'h1335, 1'b0, 1'b1, 2'd1);
      single_op("t4.03_01",   1, 16'h0003, 16'h0001, 16'h0000, 1'b0, 1'b0, 2'd2);
      single_op("t4.5a3c",    2, 16'h5A3C, 16'h1234, 16'h6C60, 1'b0, 1'b0, 2'd3);
      single_op("t4.8f00",    0, 16'h8F00, 16'h7100, 16'h0000, 1'b1, 1'b1, 2'd3);
      single_op("t4.80_80",   3, 16'h0080, 16'h0080, 16'h0100, 1'b0, 1'b1, 2'd3);

      // ---- 5: reset while S1 and S2 are full
      do_reset();
      rsp_ready = 1'b0;
      set_op(0, 16'h0001, 16'h0002);
      set_op(1, 16'h0004, 16'h0008);
      req_valid = 4'b0011;
      tick();
      tick();
      req_valid = '0;
      check("t5.full", rsp_valid, 1);
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      rsp_ready = 1'b1;
      check("t5.rsp_valid", rsp_valid, 0);
      check("t5.rsp_sum",   rsp_sum,   0);
      req_valid = 4'b1111;
      #1;
      check("t5.rr_ptr0", req_ready, 4'b0001);
      req_valid = '0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("t5.no_stale%0d", k), rsp_valid, 0);
      end

      // ---- 6: error counter saturation (CNT_W=2)
      do_reset();
      single_op("t6.m1", 0, 16'h00FF, 16'h0001, 16'h00FC, 1'b0, 1'b0, 2'd1);
      single_op("t6.m2", 1, 16'h0003, 16'h0001, 16'h0000, 1'b0, 1'b0, 2'd2);
      single_op("t6.m3", 2, 16'h5A3C, 16'h1234, 16'h6C60, 1'b0, 1'b0, 2'd3);
      single_op("t6.m4", 3, 16'h00FF, 16'h0001, 16'h00FC, 1'b0, 1'b0, 2'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
